// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, types and block-assembly helpers for the AES feeder
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES_WORD_W    = 32;
    localparam int WORDS_PER_BLK = 4;
    localparam int AES_PIPE_LAT  = 10;

    typedef logic [AES_BLK_W-1:0]  aes_block_t;
    typedef logic [AES_BLK_W-1:0]  aes_key_t;
    typedef logic [AES_WORD_W-1:0] aes_word_t;

    // Slot 0 is the most significant word of the block.
    function automatic aes_block_t put_word(input aes_block_t blk, input logic [1:0] slot,
                                            input aes_word_t w);
        aes_block_t r;
        r = blk;
        case (slot)
            2'd0: r[127:96] = w;
            2'd1: r[95:64]  = w;
            2'd2: r[63:32]  = w;
            2'd3: r[31:0]   = w;
        endcase
        return r;
    endfunction

    // Clears every slot after 'slot', used when a short block is padded out.
    function automatic aes_block_t zero_after(input aes_block_t blk, input logic [1:0] slot);
        aes_block_t r;
        r = blk;
        case (slot)
            2'd0: r[95:0] = '0;
            2'd1: r[63:0] = '0;
            2'd2: r[31:0] = '0;
            2'd3: r = blk;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_valid_delay.sv
// rtl/aes_valid_delay.sv - DEPTH-stage {valid,tag} shift register tracking blocks through the core
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_tag    block entering the core this cycle and its tag
//   out_valid, out_tag  block whose result leaves the core this cycle (tag is 0 when not valid)
//   any_valid           at least one tracked block is in flight
module aes_valid_delay #(
    parameter int DEPTH = 10,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             any_valid
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][TAG_W-1:0] tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld[0] <= in_valid;
            // Tags of empty slots are forced to zero so out_tag never shows stale data.
            tag[0] <= in_valid ? in_tag : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - assembles 32-bit plaintext words into AES-128 blocks and tracks results
//
// Optional feature macro: AES_LOADER_PAD_EN (adds word_last, zero-pads short blocks).
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   key_in, key_we          cipher key and single-cycle write strobe
//   word_in, word_valid     plaintext word stream, first word lands in [127:96]
//   word_last               (AES_LOADER_PAD_EN only) final word of a short block
//   word_ready              word accepted this cycle when word_valid is high
//   flush                   drop any partially assembled block
//   data_out, key_out       block and key to the core, qualified by issue
//   issue                   data_out/key_out carry a real block this cycle
//   res_valid, res_tag      core output carries a real ciphertext, and its tag
//   busy                    partial block held or any block in flight
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int PIPE_LAT = AES_PIPE_LAT,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [127:0]     key_in,
    input  logic             key_we,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
`ifdef AES_LOADER_PAD_EN
    input  logic             word_last,
`endif
    output logic             word_ready,
    input  logic             flush,
    output logic [127:0]     data_out,
    output logic [127:0]     key_out,
    output logic             issue,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    logic [1:0]       wcnt;
    aes_block_t       asm_q;
    aes_block_t       asm_next;
    aes_key_t         key_act;
    aes_key_t         key_shadow;
    logic             pending;
    logic             flush_q;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] issue_tag;
    logic             last_w;
    logic             xfer;
    logic             blk_done;
    logic             key_direct;
    logic             any_inflight;

`ifdef AES_LOADER_PAD_EN
    assign last_w = word_last;
`else
    assign last_w = 1'b0;
`endif

    // The only stall is the cycle following a flush; a word offered together
    // with flush is discarded regardless.
    assign word_ready = ~flush_q;
    assign xfer       = word_valid & word_ready & ~flush;
    assign blk_done   = xfer & ((wcnt == 2'd3) | last_w);
    // Between blocks a key write takes effect directly; mid-block it is deferred.
    assign key_direct = key_we & (wcnt == 2'd0) & ~xfer;

    always_comb begin
        asm_next = put_word(asm_q, wcnt, word_in);
        if (last_w) begin
            asm_next = zero_after(asm_next, wcnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt       <= '0;
            asm_q      <= '0;
            key_act    <= '0;
            key_shadow <= '0;
            pending    <= 1'b0;
            flush_q    <= 1'b0;
            tag_cnt    <= '0;
            issue_tag  <= '0;
            issue      <= 1'b0;
            data_out   <= '0;
            key_out    <= '0;
        end else begin
            flush_q <= flush;
            issue   <= 1'b0;

            if (flush) begin
                wcnt  <= '0;
                asm_q <= '0;
            end else if (xfer) begin
                asm_q <= asm_next;
                wcnt  <= blk_done ? 2'd0 : wcnt + 2'd1;
            end

            if (blk_done) begin
                issue     <= 1'b1;
                data_out  <= asm_next;
                key_out   <= key_act;
                issue_tag <= tag_cnt;
                tag_cnt   <= tag_cnt + 1'b1;
            end

            // The deferred key is swapped in during the issue cycle, after the
            // issued block has already latched the previous key. A key write in
            // that same cycle is newer and therefore wins.
            if (key_direct) begin
                key_act <= key_in;
                pending <= 1'b0;
            end else begin
                if (issue && pending) begin
                    key_act <= key_shadow;
                    pending <= 1'b0;
                end
                if (key_we) begin
                    key_shadow <= key_in;
                    pending    <= 1'b1;
                end
            end
        end
    end

    aes_valid_delay #(
        .DEPTH (PIPE_LAT),
        .TAG_W (TAG_W)
    ) u_delay (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (issue),
        .in_tag    (issue_tag),
        .out_valid (res_valid),
        .out_tag   (res_tag),
        .any_valid (any_inflight)
    );

    assign busy = (wcnt != 2'd0) | any_inflight;

endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - self-checking bench for aes_block_loader with a reference model
module tb_aes_block_loader;

    localparam int PIPE_LAT = 10;
    localparam int TAG_W    = 4;
`ifdef AES_LOADER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h0f1571c947d9e8590cb7add6af7f6798;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [127:0]     key_in = '0;
    logic             key_we = 1'b0;
    logic [31:0]      word_in = '0;
    logic             word_valid = 1'b0;
    logic             word_last = 1'b0;
    logic             flush = 1'b0;
    logic             word_ready;
    logic [127:0]     data_out;
    logic [127:0]     key_out;
    logic             issue;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    always #5 clk = ~clk;

    aes_block_loader #(.PIPE_LAT(PIPE_LAT), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_we     (key_we),
        .word_in    (word_in),
        .word_valid (word_valid),
`ifdef AES_LOADER_PAD_EN
        .word_last  (word_last),
`endif
        .word_ready (word_ready),
        .flush      (flush),
        .data_out   (data_out),
        .key_out    (key_out),
        .issue      (issue),
        .res_valid  (res_valid),
        .res_tag    (res_tag),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference state, expressed as the loader's visible rules.
    int           m_wcnt;
    logic [31:0]  m_slot[4];
    logic [127:0] m_ka, m_sh, m_data, m_key;
    bit           m_pend, m_issue, m_flush_prev;
    int           m_tag;
    int           hist_cyc[$];
    int           hist_tag[$];
    bit           e_res_valid, e_busy;
    int           e_res_tag;

    task automatic model_reset();
        m_wcnt = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_ka = '0; m_sh = '0; m_data = '0; m_key = '0;
        m_pend = 0; m_issue = 0; m_flush_prev = 0; m_tag = 0;
        hist_cyc.delete();
        hist_tag.delete();
        e_res_valid = 0; e_busy = 0; e_res_tag = 0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, and
    // returns 1 time unit after the edge with expectations up to date.
    task automatic tick(input bit wv, input logic [31:0] w, input bit fl,
                        input bit kwe, input logic [127:0] k, input bit last);
        bit xfer, direct, done;
        word_valid = wv; word_in = w; flush = fl;
        key_we = kwe; key_in = k; word_last = last;
        xfer   = wv && !m_flush_prev && !fl;
        direct = kwe && (m_wcnt == 0) && !xfer;
        done   = 0;
        if (fl) begin
            m_wcnt = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
        end else if (xfer) begin
            m_slot[m_wcnt] = w;
            if (m_wcnt == 3 || (PAD && last)) begin
                for (int i = m_wcnt + 1; i < 4; i++) m_slot[i] = '0;
                done   = 1;
                m_data = {m_slot[0], m_slot[1], m_slot[2], m_slot[3]};
                m_key  = m_ka;
                hist_cyc.push_back(cyc + 1);
                hist_tag.push_back(m_tag);
                m_tag  = (m_tag + 1) % (1 << TAG_W);
                m_wcnt = 0;
            end else begin
                m_wcnt = m_wcnt + 1;
            end
        end
        if (direct) begin
            m_ka = k; m_pend = 0;
        end else begin
            if (m_issue && m_pend) begin m_ka = m_sh; m_pend = 0; end
            if (kwe) begin m_sh = k; m_pend = 1; end
        end
        m_issue = done;
        m_flush_prev = fl;
        @(posedge clk);
        #1;
        cyc++;
        e_res_valid = 0; e_res_tag = 0; e_busy = (m_wcnt != 0);
        foreach (hist_cyc[i]) begin
            if (hist_cyc[i] + PIPE_LAT == cyc) begin e_res_valid = 1; e_res_tag = hist_tag[i]; end
            if (cyc >= hist_cyc[i] + 1 && cyc <= hist_cyc[i] + PIPE_LAT) e_busy = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, 0, 0, '0, 0);
    endtask

    task automatic word(input logic [31:0] w);
        tick(1, w, 0, 0, '0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        word_valid = 0; flush = 0; key_we = 0; word_last = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        idle(20);
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", issue); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_word_ready: got %b want 1", word_ready); end
        checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    endtask

    task automatic test_known_vector();
        int n;
        apply_reset();
        tick(0, '0, 0, 1, K1, 0);
        word(32'h00112233); word(32'h44556677); word(32'h8899aabb); word(32'hccddeeff);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL kv_issue: got %b want 1", issue); end
        checks++; if (data_out !== 128'h00112233445566778899aabbccddeeff) begin
            errors++; $display("FAIL kv_data: got %h want 00112233445566778899aabbccddeeff", data_out); end
        checks++; if (key_out !== K1) begin errors++; $display("FAIL kv_key: got %h want %h", key_out, K1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kv_busy_issue_cycle: got %b want 0", busy); end
        n = 0;
        while (res_valid !== 1'b1 && n < 3 * PIPE_LAT) begin idle(1); n++; end
        checks++; if (n != PIPE_LAT) begin errors++; $display("FAIL kv_latency: got %0d want %0d", n, PIPE_LAT); end
        checks++; if (res_tag !== 4'd0) begin errors++; $display("FAIL kv_tag: got %0d want 0", res_tag); end
    endtask

    task automatic test_midblock_key();
        apply_reset();
        tick(0, '0, 0, 1, K1, 0);
        word(32'h00112233); word(32'h44556677);
        tick(1, 32'h8899aabb, 0, 1, K2, 0);
        word(32'hccddeeff);
        checks++; if (key_out !== K1) begin errors++; $display("FAIL mk_old_key: got %h want %h", key_out, K1); end
        idle(2);
        word(32'h01234567); word(32'h89abcdef); word(32'hfedcba98); word(32'h76543210);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mk_issue2: got %b want 1", issue); end
        checks++; if (key_out !== K2) begin errors++; $display("FAIL mk_new_key: got %h want %h", key_out, K2); end
        checks++; if (data_out !== 128'h0123456789abcdeffedcba9876543210) begin
            errors++; $display("FAIL mk_data2: got %h want 0123456789abcdeffedcba9876543210", data_out); end
        idle(PIPE_LAT);
        checks++; if (res_valid !== 1'b1 || res_tag !== 4'd1) begin
            errors++; $display("FAIL mk_res_tag: got v=%b t=%0d want v=1 t=1", res_valid, res_tag); end
    endtask

    task automatic test_flush();
        apply_reset();
        tick(0, '0, 0, 1, K1, 0);
        word(32'haaaa0000); word(32'haaaa0001);
        tick(1, 32'hdead0000, 1, 0, '0, 0);
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_low: got %b want 0", word_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy: got %b want 0", busy); end
        word(32'hdead0001);
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL fl_ready_back: got %b want 1", word_ready); end
        word(32'h10000000); word(32'h20000000); word(32'h30000000); word(32'h40000000);
        checks++; if (issue !== 1'b1 || data_out !== 128'h10000000200000003000000040000000) begin
            errors++; $display("FAIL fl_fresh_block: got i=%b %h want i=1 10000000200000003000000040000000", issue, data_out); end
        word(32'h1); word(32'h2); word(32'h3);
        tick(1, 32'h4, 1, 0, '0, 0);
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL fl_priority: got %b want 0", issue); end
    endtask

    task automatic test_random();
        bit wv, fl, kwe, last;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            wv   = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 29) == 0);
            kwe  = ($urandom_range(0, 9) == 0);
            last = ($urandom_range(0, 7) == 0);
            tick(wv, $urandom, fl, kwe, {$urandom, $urandom, $urandom, $urandom}, last);
            checks++; if (issue !== m_issue) begin errors++; $display("FAIL rnd_issue c%0d: got %b want %b", cyc, issue, m_issue); end
            checks++; if (data_out !== m_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, data_out, m_data); end
            checks++; if (key_out !== m_key) begin errors++; $display("FAIL rnd_key c%0d: got %h want %h", cyc, key_out, m_key); end
            checks++; if (word_ready !== !m_flush_prev) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, word_ready, !m_flush_prev); end
            checks++; if (res_valid !== e_res_valid) begin errors++; $display("FAIL rnd_res_valid c%0d: got %b want %b", cyc, res_valid, e_res_valid); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, e_busy); end
            if (e_res_valid) begin
                checks++; if (res_tag !== TAG_W'(e_res_tag)) begin errors++; $display("FAIL rnd_tag c%0d: got %0d want %0d", cyc, res_tag, e_res_tag); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        apply_reset();
        tick(0, '0, 0, 1, K1, 0);
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) word($urandom);
        word(32'h1); word(32'h2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b want 1", busy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({issue, res_valid, busy, data_out, key_out, res_tag} !== '0) begin
            errors++; $display("FAIL rm_outputs_zero: got i=%b v=%b b=%b d=%h k=%h t=%0d want all 0",
                               issue, res_valid, busy, data_out, key_out, res_tag); end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rm_word_ready: got %b want 1", word_ready); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * PIPE_LAT; i++) begin
            idle(1);
            if (res_valid !== 1'b0) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rm_no_res_after: got res_valid=1 want 0"); end
    endtask

    task automatic test_pad();
        apply_reset();
        tick(0, '0, 0, 1, K1, 0);
        word(32'h11111111);
        tick(1, 32'h22222222, 0, 0, '0, 1);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL pad_issue: got %b want 1", issue); end
        checks++; if (data_out !== 128'h11111111222222220000000000000000) begin
            errors++; $display("FAIL pad_data: got %h want 11111111222222220000000000000000", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pad_wcnt_cleared: got busy=%b want 0", busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_known_vector();
        test_midblock_key();
        test_flush();
        test_reset_midflight();
        if (PAD) test_pad();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
